// File: rtl/serial_pkg.sv
// Shared state type and default geometry for the oversampled serial receive framer.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/serial_bit_timer.sv
// Oversample counter: midBit fires half a bit after clear, bitTick every OVERSAMPLE cycles after that.
// Both strobes are combinational decodes of the counter; no backpressure.
module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic midBit,
    output logic bitTick
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
        end
    end

    assign midBit  = run && (cnt == MID_CNT);
    assign bitTick = run && (cnt == LAST_CNT);

endmodule

// File: rtl/serial_frame_receiver.sv
// Oversampled serial framer: start/data/stop sampling, stop edge at T0+OS/2+OS*(DATA_BITS+1), no backpressure.
// SERIAL_RX_PARITY_EN adds a parity bit period, parityOdd input and parityError pulse.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serialDataIn,
    output logic                 enable,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 charReceived,
    output logic                 frameError
`ifdef SERIAL_RX_PARITY_EN
    ,
    input  logic                 parityOdd,
    output logic                 parityError
`endif
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [BCW-1:0]       bitcnt;
    logic                 midBit;
    logic                 bitTick;
    logic                 timer_clear;
    logic                 timer_run;

    // Counter restarts on the start edge and again at mid-start, so later ticks land mid-bit.
    assign timer_clear = ((state == IDLE) && !serialDataIn) || ((state == START) && midBit);
    assign timer_run   = (state != IDLE) && (state != BREAK);

    serial_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .midBit  (midBit),
        .bitTick (bitTick)
    );

`ifdef SERIAL_RX_PARITY_EN
    logic pbit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift        <= '0;
            bitcnt       <= '0;
            dataOut      <= '0;
            enable       <= 1'b0;
            charReceived <= 1'b0;
            frameError   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            pbit         <= 1'b0;
            parityError  <= 1'b0;
`endif
        end else begin
            charReceived <= 1'b0;
            frameError   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parityError  <= 1'b0;
`endif
            enable <= (state inside {START, DATA, PARITY, STOP});
            case (state)
                IDLE: begin
                    if (!serialDataIn) begin
                        state  <= START;
                        bitcnt <= '0;
                    end
                end
                START: begin
                    if (midBit) begin
                        state <= serialDataIn ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        shift  <= {serialDataIn, shift[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + BCW'(1);
                        if (bitcnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (bitTick) begin
                        pbit  <= serialDataIn;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bitTick) begin
                        if (serialDataIn) begin
                            dataOut      <= shift;
                            charReceived <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                            parityError  <= ((^shift) ^ pbit) != parityOdd;
`endif
                            state        <= IDLE;
                        end else begin
                            frameError <= 1'b1;
                            state      <= BREAK;
                        end
                    end
                end
                // A line stuck low after a bad stop must return high before a new start is armed.
                BREAK: begin
                    if (serialDataIn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
